// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg
//   Shared constants for the zeroheti OBI arbiter slice.
//   ObiArbMgrDbg / ObiArbMgrCore : manager lane indices (debug SBA, core fetch)
//   NumObiArbMgrs                : number of arbitrated managers
package zeroheti_pkg;

    localparam int unsigned ObiArbMgrDbg  = 0;
    localparam int unsigned ObiArbMgrCore = 1;
    localparam int unsigned NumObiArbMgrs = 2;

    // One bit is enough to name either of the two managers.
    typedef logic [0:0] obi_arb_mgr_t;

endpackage

// File: rtl/zeroheti_id_fifo.sv
// zeroheti_id_fifo
//   Small FIFO that remembers which manager owns each outstanding OBI
//   transaction so responses can be routed back in grant order.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset
//     push_i/data_i: write an entry (ignored when full)
//     pop_i/data_o : drop the head entry (ignored when empty); data_o is head
//     full_o/empty_o: occupancy flags
module zeroheti_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

endmodule

// File: rtl/zeroheti_obi_arb.sv
// zeroheti_obi_arb
//   Two-manager round-robin OBI arbiter in front of one shared subordinate.
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     m_req_i..m_wdata_i      : per-manager address phase (0 = debug, 1 = core)
//     m_gnt_o                 : per-manager grant
//     m_rvalid_o/rdata/err    : per-manager response, routed by grant order
//     s_*                     : shared subordinate address/response phase
//     busy_o                  : a transaction is outstanding
//     stray_rsp_o             : response arrived with nothing outstanding
module zeroheti_obi_arb
    import zeroheti_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [NumObiArbMgrs-1:0]                     m_req_i,
    output logic [NumObiArbMgrs-1:0]                     m_gnt_o,
    input  logic [NumObiArbMgrs-1:0][AddrWidth-1:0]      m_addr_i,
    input  logic [NumObiArbMgrs-1:0]                     m_we_i,
    input  logic [NumObiArbMgrs-1:0][DataWidth/8-1:0]    m_be_i,
    input  logic [NumObiArbMgrs-1:0][DataWidth-1:0]      m_wdata_i,
    output logic [NumObiArbMgrs-1:0]                     m_rvalid_o,
    output logic [NumObiArbMgrs-1:0][DataWidth-1:0]      m_rdata_o,
    output logic [NumObiArbMgrs-1:0]                     m_err_o,
    output logic                                         s_req_o,
    input  logic                                         s_gnt_i,
    output logic [AddrWidth-1:0]                         s_addr_o,
    output logic                                         s_we_o,
    output logic [DataWidth/8-1:0]                       s_be_o,
    output logic [DataWidth-1:0]                         s_wdata_o,
    input  logic                                         s_rvalid_i,
    input  logic [DataWidth-1:0]                         s_rdata_i,
    input  logic                                         s_err_i,
    output logic                                         busy_o,
    output logic                                         stray_rsp_o
);

    obi_arb_mgr_t r_rr_ptr;
    obi_arb_mgr_t w_winner;
    obi_arb_mgr_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_grant;
    logic         w_pop;

    // A lone requester wins outright; on contention the pointer decides.
    always_comb begin
        w_winner = r_rr_ptr;
        case (m_req_i)
            2'b01:   w_winner = obi_arb_mgr_t'(ObiArbMgrDbg);
            2'b10:   w_winner = obi_arb_mgr_t'(ObiArbMgrCore);
            default: w_winner = r_rr_ptr;
        endcase
    end

    // Full blocks new requests even if a response frees a slot this cycle.
    assign s_req_o   = (|m_req_i) & ~w_full & ~rst_i;
    assign w_grant   = s_req_o & s_gnt_i;
    assign s_addr_o  = m_addr_i[w_winner];
    assign s_we_o    = m_we_i[w_winner];
    assign s_be_o    = m_be_i[w_winner];
    assign s_wdata_o = m_wdata_i[w_winner];

    assign w_pop       = s_rvalid_i & ~w_empty & ~rst_i;
    assign stray_rsp_o = s_rvalid_i & w_empty & ~rst_i;
    assign busy_o      = ~w_empty;
    assign m_rdata_o   = {s_rdata_i, s_rdata_i};

    always_comb begin
        m_gnt_o            = '0;
        m_rvalid_o         = '0;
        m_err_o            = '0;
        m_gnt_o[w_winner]  = w_grant;
        m_rvalid_o[w_head] = w_pop;
        m_err_o[w_head]    = w_pop & s_err_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= obi_arb_mgr_t'(ObiArbMgrDbg);
        end else if (w_grant) begin
            r_rr_ptr <= ~w_winner;
        end
    end

    zeroheti_id_fifo #(
        .Depth (MaxTrans),
        .Width (1)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .data_i  (w_winner),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule

// File: tb/tb_zeroheti_obi_arb.sv
module tb_zeroheti_obi_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       m_req;
    logic [1:0]       m_gnt;
    logic [1:0][31:0] m_addr;
    logic [1:0]       m_we;
    logic [1:0][3:0]  m_be;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_rvalid;
    logic [1:0][31:0] m_rdata;
    logic [1:0]       m_err;
    logic             s_req;
    logic             s_gnt;
    logic [31:0]      s_addr;
    logic             s_we;
    logic [3:0]       s_be;
    logic [31:0]      s_wdata;
    logic             s_rvalid;
    logic [31:0]      s_rdata;
    logic             s_err;
    logic             busy;
    logic             stray;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    always #5 clk = ~clk;

    zeroheti_obi_arb #(
        .AddrWidth (32),
        .DataWidth (32),
        .MaxTrans  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m_req_i     (m_req),
        .m_gnt_o     (m_gnt),
        .m_addr_i    (m_addr),
        .m_we_i      (m_we),
        .m_be_i      (m_be),
        .m_wdata_i   (m_wdata),
        .m_rvalid_o  (m_rvalid),
        .m_rdata_o   (m_rdata),
        .m_err_o     (m_err),
        .s_req_o     (s_req),
        .s_gnt_i     (s_gnt),
        .s_addr_o    (s_addr),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_wdata_o   (s_wdata),
        .s_rvalid_i  (s_rvalid),
        .s_rdata_i   (s_rdata),
        .s_err_i     (s_err),
        .busy_o      (busy),
        .stray_rsp_o (stray)
    );

    // Move to the next cycle: past the rising edge, onto the falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b0; s_err = 1'b0;
        next_cycle(); next_cycle(); settle();
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL rst_sreq: got %b want 0", s_req); end
        total++; if (m_gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", m_gnt); end
        total++; if (m_rvalid !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", m_rvalid); end
        total++; if (m_err !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", m_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (stray !== 1'b0) begin bad++; $display("FAIL rst_stray: got %b want 0", stray); end
        m_req = 2'b00; s_gnt = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single();
        m_req = 2'b01; s_gnt = 1'b1; settle();
        total++; if (m_gnt !== 2'b01) begin bad++; $display("FAIL single_gnt: got %b want 01", m_gnt); end
        total++; if (s_addr !== A0) begin bad++; $display("FAIL single_addr: got %h want %h", s_addr, A0); end
        total++; if (s_be !== 4'hF || s_we !== 1'b1 || s_wdata !== 32'hAAAA_0000) begin
            bad++; $display("FAIL single_fields: got be=%h we=%b wd=%h want F 1 aaaa0000", s_be, s_we, s_wdata); end
        next_cycle();
        m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; settle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        total++; if (m_rvalid !== 2'b01) begin bad++; $display("FAIL single_rvalid: got %b want 01", m_rvalid); end
        total++; if (m_rdata[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", m_rdata[0]); end
        next_cycle();
        s_rvalid = 1'b0; settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_gnt [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0]  exp_rv  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] exp_a   [4] = '{A0, A1, A0, A1};
        // Pointer back to manager 0 so the alternation starts on lane 0.
        rst = 1'b1; next_cycle(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_req = (i < 4) ? 2'b11 : 2'b00;
            s_gnt = 1'b1;
            s_rvalid = (i > 0);
            s_rdata = 32'h0000_0100 + i;
            settle();
            total++; if (m_gnt !== exp_gnt[i]) begin bad++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, m_gnt, exp_gnt[i]); end
            total++; if (m_rvalid !== exp_rv[i]) begin bad++; $display("FAIL cont_rv[%0d]: got %b want %b", i, m_rvalid, exp_rv[i]); end
            if (i < 4) begin
                total++; if (s_addr !== exp_a[i]) begin bad++; $display("FAIL cont_addr[%0d]: got %h want %h", i, s_addr, exp_a[i]); end
            end
            next_cycle();
        end
        s_rvalid = 1'b0; s_gnt = 1'b0; settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_drain: got %b want 0", busy); end
    endtask

    task automatic test_full();
        // Pointer is at manager 0 after an even number of grants.
        s_gnt = 1'b1; m_req = 2'b01; next_cycle();
        m_req = 2'b10; next_cycle();
        m_req = 2'b01; settle();
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL full_sreq: got %b want 0", s_req); end
        total++; if (m_gnt !== 2'b00) begin bad++; $display("FAIL full_gnt: got %b want 00", m_gnt); end
        next_cycle();
        s_rvalid = 1'b1; settle();
        total++; if (m_gnt !== 2'b00) begin bad++; $display("FAIL full_nobypass: got %b want 00", m_gnt); end
        total++; if (m_rvalid !== 2'b01) begin bad++; $display("FAIL full_pop: got %b want 01", m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; settle();
        total++; if (m_gnt !== 2'b01) begin bad++; $display("FAIL full_regrant: got %b want 01", m_gnt); end
        next_cycle();
        // Order now: manager 1 then manager 0 (write pointer wrapped).
        m_req = 2'b00; s_rvalid = 1'b1; settle();
        total++; if (m_rvalid !== 2'b10) begin bad++; $display("FAIL full_order1: got %b want 10", m_rvalid); end
        next_cycle(); settle();
        total++; if (m_rvalid !== 2'b01) begin bad++; $display("FAIL full_order2: got %b want 01", m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; s_gnt = 1'b0; settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_drain: got %b want 0", busy); end
    endtask

    task automatic test_err();
        s_gnt = 1'b1; m_req = 2'b10; settle();
        total++; if (m_gnt !== 2'b10) begin bad++; $display("FAIL err_gnt: got %b want 10", m_gnt); end
        next_cycle();
        m_req = 2'b00; s_rvalid = 1'b1; s_err = 1'b1; settle();
        total++; if (m_err !== 2'b10) begin bad++; $display("FAIL err_route: got %b want 10", m_err); end
        total++; if (m_rvalid !== 2'b10) begin bad++; $display("FAIL err_rvalid: got %b want 10", m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; s_err = 1'b0; m_req = 2'b01; next_cycle();
        m_req = 2'b00; s_rvalid = 1'b1; settle();
        total++; if (m_err !== 2'b00 || m_rvalid !== 2'b01) begin
            bad++; $display("FAIL err_clean: got err=%b rv=%b want 00 01", m_err, m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; s_gnt = 1'b0;
    endtask

    task automatic test_stray();
        s_rvalid = 1'b1; settle();
        total++; if (stray !== 1'b1) begin bad++; $display("FAIL stray_pulse: got %b want 1", stray); end
        total++; if (m_rvalid !== 2'b00) begin bad++; $display("FAIL stray_rvalid: got %b want 00", m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; settle();
        total++; if (stray !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stray_after: got stray=%b busy=%b want 0 0", stray, busy); end
    endtask

    task automatic test_reset_mid();
        s_gnt = 1'b1; m_req = 2'b10; next_cycle();
        m_req = 2'b00; s_gnt = 1'b0; settle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
        rst = 1'b1; next_cycle();
        rst = 1'b0; s_rvalid = 1'b1; settle();
        total++; if (stray !== 1'b1 || m_rvalid !== 2'b00) begin
            bad++; $display("FAIL rmid_stray: got stray=%b rv=%b want 1 00", stray, m_rvalid); end
        next_cycle();
        s_rvalid = 1'b0; m_req = 2'b11; s_gnt = 1'b1; settle();
        total++; if (m_gnt !== 2'b01) begin bad++; $display("FAIL rmid_ptr: got %b want 01", m_gnt); end
        next_cycle();
        m_req = 2'b00; s_gnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
        m_addr = {A1, A0};
        m_we = 2'b01;
        m_be = {4'h3, 4'hF};
        m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_err();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
